// File: rtl/div_rsv_station.sv
// div_rsv_station: reservation station feeding a fixed-latency divider with CDB write-back.
// Define DIV_RSV_STALL_CNT_EN to add the stall_cnt issue-stall counter output.
module div_rsv_station #(
  parameter int NUM_ENTRIES = 2,
  parameter int TAG_W = 4,
  parameter int TAG_BASE = 1,
  parameter int DIV_LATENCY = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [31:0]      issue_vj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [31:0]      issue_vk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             fu_en,
  output logic [31:0]      fu_a,
  output logic [31:0]      fu_b,
  input  logic [31:0]      fu_res,
  output logic             wb_req,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  input  logic             wb_grant
`ifdef DIV_RSV_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);
  localparam int IW = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;
  localparam int CW = $clog2(DIV_LATENCY + 1);
  typedef enum logic [2:0] {E_FREE, E_WAIT, E_READY, E_EXEC, E_DONE} ent_t;
  typedef enum logic [1:0] {U_IDLE, U_RUN, U_DONE, U_DRAIN} unit_t;
  ent_t             st[NUM_ENTRIES], st_n[NUM_ENTRIES];
  logic [TAG_W-1:0] qj[NUM_ENTRIES], qj_n[NUM_ENTRIES], qk[NUM_ENTRIES], qk_n[NUM_ENTRIES];
  logic [31:0]      vj[NUM_ENTRIES], vj_n[NUM_ENTRIES], vk[NUM_ENTRIES], vk_n[NUM_ENTRIES];
  unit_t            unit, unit_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    free_idx, rdy_idx, xidx;
  logic             free_hit, rdy_hit, do_issue, do_disp, do_grant, expire_ok, snp_j, snp_k;
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    rdy_hit = 1'b0;
    rdy_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (st[i] == E_FREE) begin free_hit = 1'b1; free_idx = IW'(i); end
      if (st[i] == E_READY) begin rdy_hit = 1'b1; rdy_idx = IW'(i); end
    end
  end
  assign issue_ready = free_hit;
  assign issue_tag = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
  assign do_issue = issue_valid && free_hit && !flush;
  assign do_disp = unit == U_IDLE && rdy_hit && !flush;
  assign do_grant = unit == U_DONE && wb_grant && !flush;
  assign expire_ok = unit == U_RUN && cnt == '0 && !flush;
  // an operand broadcast in the issue cycle is taken straight off the CDB
  assign snp_j = cdb_valid && issue_qj != '0 && issue_qj == cdb_tag;
  assign snp_k = cdb_valid && issue_qk != '0 && issue_qk == cdb_tag;
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      st_n[i] = st[i];
      qj_n[i] = qj[i];
      vj_n[i] = vj[i];
      qk_n[i] = qk[i];
      vk_n[i] = vk[i];
      if (st[i] == E_WAIT) begin
        if (cdb_valid && qj[i] != '0 && qj[i] == cdb_tag) begin qj_n[i] = '0; vj_n[i] = cdb_data; end
        if (cdb_valid && qk[i] != '0 && qk[i] == cdb_tag) begin qk_n[i] = '0; vk_n[i] = cdb_data; end
        st_n[i] = (qj_n[i] == '0 && qk_n[i] == '0) ? E_READY : E_WAIT;
      end
      if (do_issue && free_idx == IW'(i)) begin
        qj_n[i] = snp_j ? '0 : issue_qj;
        vj_n[i] = snp_j ? cdb_data : issue_vj;
        qk_n[i] = snp_k ? '0 : issue_qk;
        vk_n[i] = snp_k ? cdb_data : issue_vk;
        st_n[i] = (qj_n[i] == '0 && qk_n[i] == '0) ? E_READY : E_WAIT;
      end
      if (do_disp && rdy_idx == IW'(i)) st_n[i] = E_EXEC;
      if (expire_ok && xidx == IW'(i)) st_n[i] = E_DONE;
      if (do_grant && xidx == IW'(i)) st_n[i] = E_FREE;
      if (flush) st_n[i] = E_FREE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        st[i] <= E_FREE;
        qj[i] <= '0;
        vj[i] <= '0;
        qk[i] <= '0;
        vk[i] <= '0;
      end
    end else begin
      st <= st_n;
      qj <= qj_n;
      vj <= vj_n;
      qk <= qk_n;
      vk <= vk_n;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit <= U_IDLE;
      cnt <= '0;
    end else begin
      unit <= unit_n;
      cnt <= cnt_n;
    end
  end
  // a flushed op still occupies the divider, so DRAIN waits out its latency
  always_comb begin
    unit_n = unit;
    cnt_n = (cnt != '0) ? cnt - CW'(1) : cnt;
    if (do_disp) begin
      unit_n = U_RUN;
      cnt_n = CW'(DIV_LATENCY - 1);
    end else if (unit == U_RUN) unit_n = (cnt == '0) ? (flush ? U_IDLE : U_DONE) : (flush ? U_DRAIN : U_RUN);
    else if (unit == U_DRAIN && cnt == '0) unit_n = U_IDLE;
    else if (unit == U_DONE && (flush || wb_grant)) unit_n = U_IDLE;
  end
  always_comb begin
    fu_en = unit == U_RUN && cnt == CW'(DIV_LATENCY - 1);
    wb_req = unit == U_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_a <= '0;
      fu_b <= '0;
      xidx <= '0;
      wb_tag <= '0;
      wb_data <= '0;
    end else begin
      if (do_disp) begin
        fu_a <= vj[rdy_idx];
        fu_b <= vk[rdy_idx];
        xidx <= rdy_idx;
      end
      if (expire_ok) begin
        wb_data <= fu_res;
        wb_tag <= TAG_W'(TAG_BASE) + TAG_W'(xidx);
      end
    end
  end
`ifdef DIV_RSV_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (issue_valid && !issue_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_div_rsv_station.sv
// tb_div_rsv_station: directed vectors and corner sequences for div_rsv_station.
module tb_div_rsv_station;
  localparam int LAT = 24;
  logic clk = 0, rst_n = 0, flush = 0, issue_valid = 0, cdb_valid = 0, wb_grant = 0;
  logic [3:0] issue_qj = 0, issue_qk = 0, cdb_tag = 0, issue_tag, wb_tag;
  logic [31:0] issue_vj = 0, issue_vk = 0, cdb_data = 0, fu_a, fu_b, fu_res, wb_data;
  logic issue_ready, fu_en, wb_req;
`ifdef DIV_RSV_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int total = 0, bad = 0;
  div_rsv_station #(.NUM_ENTRIES(2), .TAG_W(4), .TAG_BASE(1), .DIV_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_tag(issue_tag), .issue_qj(issue_qj), .issue_vj(issue_vj), .issue_qk(issue_qk),
    .issue_vk(issue_vk), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_en(fu_en), .fu_a(fu_a), .fu_b(fu_b), .fu_res(fu_res), .wb_req(wb_req), .wb_tag(wb_tag),
`ifdef DIV_RSV_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .wb_data(wb_data), .wb_grant(wb_grant));
  always #5 clk = ~clk;
  // divider model: quotient is valid only in the cycle the station should sample it
  int bc = 0;
  logic [31:0] mq = 0;
  always @(posedge clk) begin
    if (fu_en) begin
      bc <= 1;
      mq <= (fu_b == 0) ? 32'hFFFF_FFFF : fu_a / fu_b;
    end else if (bc != 0) bc <= bc + 1;
  end
  assign fu_res = (bc == LAT - 1) ? mq : 32'hDEAD_BEEF;
  typedef struct {logic [31:0] a, b, q;} vec_t;
  vec_t vecs[5];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic do_issue(input logic [3:0] qj, input logic [31:0] vj, input logic [3:0] qk, input logic [31:0] vk);
    issue_valid = 1; issue_qj = qj; issue_vj = vj; issue_qk = qk; issue_vk = vk;
    @(negedge clk);
    issue_valid = 0;
  endtask
  task automatic wait_wb(input string nm, input logic [31:0] q, input logic [3:0] tag);
    int k = 0;
    while (!wb_req && k < 100) begin @(negedge clk); k++; end
    chk({nm, "_lat"}, k, LAT);
    chk({nm, "_data"}, wb_data, q);
    chk({nm, "_tag"}, {28'd0, wb_tag}, {28'd0, tag});
  endtask
  task automatic grant(input string nm);
    wb_grant = 1;
    @(negedge clk);
    wb_grant = 0;
    chk({nm, "_req_drop"}, wb_req, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int t, first, early_wb, s_req, s_data, s_en;
    vecs[0] = '{32'd100, 32'd7, 32'd14};
    vecs[1] = '{32'd1000, 32'd10, 32'd100};
    vecs[2] = '{32'd5, 32'd9, 32'd0};
    vecs[3] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    vecs[4] = '{32'd7, 32'd0, 32'hFFFF_FFFF};
    repeat (2) @(negedge clk);
    chk("rst_ready", issue_ready, 1);
    chk("rst_fu_en", fu_en, 0);
    chk("rst_wb_req", wb_req, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fu_a", fu_a, 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("v_tag", {28'd0, issue_tag}, 1);
      do_issue(0, vecs[i].a, 0, vecs[i].b);
      chk("v_no_early_en", fu_en, 0);
      @(negedge clk);
      chk("v_en", fu_en, 1);
      chk("v_a", fu_a, vecs[i].a);
      chk("v_b", fu_b, vecs[i].b);
      wait_wb("v", vecs[i].q, 1);
      grant("v");
      chk("v_ready", issue_ready, 1);
    end
    // operand woken by a later CDB broadcast, ignoring an unrelated tag
    do_issue(3, 0, 0, 4);
    chk("s2_wait0", fu_en, 0);
    cdb_valid = 1; cdb_tag = 7; cdb_data = 99;
    @(negedge clk);
    cdb_tag = 3; cdb_data = 40;
    @(negedge clk);
    cdb_valid = 0;
    chk("s2_wait1", fu_en, 0);
    @(negedge clk);
    chk("s2_en", fu_en, 1);
    chk("s2_a", fu_a, 40);
    chk("s2_b", fu_b, 4);
    wait_wb("s2", 10, 1);
    grant("s2");
    // issue in the same cycle as the producer's broadcast
    cdb_valid = 1; cdb_tag = 5; cdb_data = 9;
    do_issue(5, 0, 0, 3);
    cdb_valid = 0;
    @(negedge clk);
    chk("s3_en", fu_en, 1);
    chk("s3_a", fu_a, 9);
    wait_wb("s3", 3, 1);
    grant("s3");
    // both entries full, write-back stalled
    chk("s4_tag_a", {28'd0, issue_tag}, 1);
    issue_valid = 1; issue_qj = 0; issue_vj = 84; issue_qk = 0; issue_vk = 4;
    @(negedge clk);
    chk("s4_tag_b", {28'd0, issue_tag}, 2);
    issue_vj = 50; issue_vk = 5;
    @(negedge clk);
    issue_valid = 0;
    chk("s4_en_a", fu_en, 1);
    chk("s4_a", fu_a, 84);
    chk("s4_full", issue_ready, 0);
    wait_wb("s4a", 21, 1);
    s_req = 0; s_data = 0; s_en = 0;
    repeat (10) begin
      @(negedge clk);
      s_req += (wb_req !== 1);
      s_data += (wb_data !== 32'd21);
      s_en += (fu_en !== 0);
    end
    chk("s4_hold_req", s_req, 0);
    chk("s4_hold_data", s_data, 0);
    chk("s4_hold_no_en", s_en, 0);
    chk("s4_still_full", issue_ready, 0);
    grant("s4a");
    chk("s4_no_en_grant", fu_en, 0);
    chk("s4_freed", issue_ready, 1);
    @(negedge clk);
    chk("s4_en_b", fu_en, 1);
    chk("s4_b_a", fu_a, 50);
    chk("s4_b_b", fu_b, 5);
    wait_wb("s4b", 10, 2);
    grant("s4b");
    // flush while running: drain, then dispatch a new op only after expiry
    do_issue(0, 60, 0, 6);
    @(negedge clk);
    chk("s5_en", fu_en, 1);
    repeat (4) @(negedge clk);
    flush = 1;
    issue_valid = 1; issue_qj = 0; issue_vj = 1; issue_qk = 0; issue_vk = 1;
    @(negedge clk);
    flush = 0;
    chk("s5_flush_req", wb_req, 0);
    chk("s5_flush_ready", issue_ready, 1);
    issue_vj = 90; issue_vk = 9;
    @(negedge clk);
    issue_valid = 0;
    t = 6; first = -1; early_wb = 0;
    while (first < 0 && t < 60) begin
      early_wb += wb_req;
      if (fu_en) first = t;
      else begin @(negedge clk); t++; end
    end
    chk("s5_first_en", first, 25);
    chk("s5_no_wb", early_wb, 0);
    chk("s5_a", fu_a, 90);
    wait_wb("s5", 10, 1);
    grant("s5");
    s_en = 0;
    repeat (3) begin @(negedge clk); s_en += fu_en; end
    chk("s5_no_ghost", s_en, 0);
    // async reset mid-run, with stall accounting while full
    issue_valid = 1; issue_qj = 0; issue_vj = 77; issue_qk = 0; issue_vk = 7;
    @(negedge clk);
    @(negedge clk);
    chk("s6_full", issue_ready, 0);
    repeat (3) @(negedge clk);
    issue_valid = 0;
`ifdef DIV_RSV_STALL_CNT_EN
    chk("s6_stall", stall_cnt, 3);
`endif
    #2 rst_n = 0;
    #1;
    chk("s6_fu_en", fu_en, 0);
    chk("s6_fu_a", fu_a, 0);
    chk("s6_fu_b", fu_b, 0);
    chk("s6_wb_req", wb_req, 0);
    chk("s6_wb_tag", {28'd0, wb_tag}, 0);
    chk("s6_wb_data", wb_data, 0);
    chk("s6_ready", issue_ready, 1);
`ifdef DIV_RSV_STALL_CNT_EN
    chk("s6_stall_rst", stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1;
    s_req = 0; s_en = 0;
    repeat (30) begin @(negedge clk); s_req += wb_req; s_en += fu_en; end
    chk("s6_no_wb", s_req, 0);
    chk("s6_no_en", s_en, 0);
    do_issue(0, 100, 0, 7);
    @(negedge clk);
    chk("s6_en", fu_en, 1);
    wait_wb("s6", 14, 1);
    grant("s6");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
